// File: rtl/pe_argmax.sv
// pe_argmax: running argmax over the NUM_CLASSES binary32 scores of one image.
// After the last class it emits the winning index and score with a one-cycle pulse.
module pe_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pe_out,
    input  logic              done_flag,
    output logic [3:0]        class_idx,
    output logic [DATA_W-1:0] max_val,
    output logic              result_valid,
    output logic              busy,
    output logic              nan_seen,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [DATA_W-1:0] NEG_ZERO  = 32'h8000_0000;
    localparam logic [3:0]        LAST_IDX  = 4'(NUM_CLASSES - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        best_idx;
    logic              best_valid;
    logic [DATA_W-1:0] best_val;

    logic              sample;
    logic              last_sample;
    logic              cand_nan;
    logic              cand_wins;
    logic              win_valid;
    logic [3:0]        win_idx;
    logic [DATA_W-1:0] win_val;

    // Monotonic unsigned key: positives above negatives, -0 folded onto +0.
    function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] z;
        z = (x == NEG_ZERO) ? '0 : x;
        return z[DATA_W-1] ? ~z : {1'b1, z[DATA_W-2:0]};
    endfunction

    // done_flag is a one-cycle strobe with no back-pressure: every strobe seen in
    // COLLECT without a simultaneous start is consumed as the next class in order.
    always_comb begin
        sample      = (state == COLLECT) && done_flag && !start;
        last_sample = sample && (cnt == LAST_IDX);
        cand_nan    = (pe_out[30:23] == 8'hFF) && (pe_out[22:0] != 23'd0);
        cand_wins   = !cand_nan &&
                      (!best_valid || (order_key(pe_out) > order_key(best_val)));
        win_valid   = best_valid || cand_wins;
        win_idx     = cand_wins ? cnt : best_idx;
        win_val     = cand_wins ? pe_out : best_val;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (last_sample) state_next = DONE;
            DONE:    state_next = start ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_val   <= '0;
            nan_seen   <= 1'b0;
            class_idx  <= '0;
            max_val    <= '0;
        end else if (start) begin
            cnt        <= '0;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_val   <= '0;
            nan_seen   <= 1'b0;
        end else if (sample) begin
            cnt <= cnt + 4'd1;
            if (cand_nan) begin
                nan_seen <= 1'b1;
            end
            if (cand_wins) begin
                best_valid <= 1'b1;
                best_idx   <= cnt;
                best_val   <= pe_out;
            end
            // An image with no non-NaN score reports class 0 with a canonical quiet NaN.
            if (last_sample) begin
                class_idx <= win_valid ? win_idx : 4'd0;
                max_val   <= win_valid ? win_val : CANON_NAN;
            end
        end
    end

    assign busy         = (state == COLLECT);
    assign result_valid = (state == DONE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_pe_argmax.sv
// Self-checking bench for pe_argmax: directed images plus randomized images
// checked against a sign/magnitude argmax reference model.
module tb_pe_argmax;
    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] pe_out;
    logic        done_flag;
    logic [3:0]  class_idx;
    logic [31:0] max_val;
    logic        result_valid;
    logic        busy;
    logic        nan_seen;
    logic [1:0]  fsm_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rv_count = 0;
    int          rv_before;

    logic [31:0] img[10];
    logic [3:0]  exp_idx;
    logic [31:0] exp_val;
    logic        exp_nan;
    logic [36:0] exp_q[$];
    logic [36:0] exp_item;

    pe_argmax #(.NUM_CLASSES(10), .DATA_W(32)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .pe_out(pe_out),
        .done_flag(done_flag),
        .class_idx(class_idx),
        .max_val(max_val),
        .result_valid(result_valid),
        .busy(busy),
        .nan_seen(nan_seen),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (result_valid === 1'b1) rv_count++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    // Real-number ordering from sign and magnitude; both zeros are equal.
    function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
        if (!a[31] && b[31]) return 1'b1;
        if (a[31] && !b[31]) return 1'b0;
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic void model_image();
        int best;
        best    = -1;
        exp_nan = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (is_nan(img[i])) exp_nan = 1'b1;
            else if (best < 0 || fp_gt(img[i], img[best])) best = i;
        end
        exp_idx = (best < 0) ? 4'd0 : 4'(best);
        exp_val = (best < 0) ? 32'h7FC0_0000 : img[best];
    endfunction

    function automatic logic [31:0] rand_score();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h0000_0000;
            2: return {r[31], 8'hFF, 23'd0};
            3: return {r[31], 8'hFF, 23'($urandom_range(1, 8388607))};
            4: return {r[31], 8'h00, r[22:0]};
            5: return {r[31], 31'h3F80_0000 + 31'($urandom_range(0, 2))};
            default: return r;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic run_image(input int gap_max, input bit do_start);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            pe_out    = img[i];
            done_flag = 1'b1;
            tick();
            done_flag = 1'b0;
            pe_out    = $urandom;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; done_flag = 1'b0; pe_out = 32'h0;
        repeat (2) tick();
        n_checks++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL reset class_idx: got %0d exp 0", class_idx); end
        n_checks++; if (max_val !== 32'h0) begin n_fail++; $display("FAIL reset max_val: got %h exp 00000000", max_val); end
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset result_valid: got %b exp 0", result_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b exp 0", busy); end
        n_checks++; if (nan_seen !== 1'b0) begin n_fail++; $display("FAIL reset nan_seen: got %b exp 0", nan_seen); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset state: got %0d exp 0", fsm_state); end
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start busy: got %b exp 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed(input string name, input int gap_max);
        model_image();
        rv_before = rv_count;
        run_image(gap_max, 1'b1);
        n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL %s result_valid: got %b exp 1", name, result_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b exp 0", name, busy); end
        n_checks++; if (class_idx !== exp_idx) begin n_fail++; $display("FAIL %s class_idx: got %0d exp %0d", name, class_idx, exp_idx); end
        n_checks++; if (max_val !== exp_val) begin n_fail++; $display("FAIL %s max_val: got %h exp %h", name, max_val, exp_val); end
        n_checks++; if (nan_seen !== exp_nan) begin n_fail++; $display("FAIL %s nan_seen: got %b exp %b", name, nan_seen, exp_nan); end
        tick();
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL %s pulse width: got %b exp 0", name, result_valid); end
        n_checks++; if (rv_count - rv_before !== 1) begin n_fail++; $display("FAIL %s pulse count: got %0d exp 1", name, rv_count - rv_before); end
    endtask

    task automatic test_basic();
        img = '{32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 0, 0, 0, 0};
        test_directed("basic", 0);
        img = '{32'hC040_0000, 32'hC030_0000, 32'hC020_0000, 32'hC010_0000, 32'hC000_0000,
                32'hBFE0_0000, 32'hBFC0_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC040_0000};
        test_directed("all_negative", 0);
    endtask

    task automatic test_ties();
        img = '{0, 0, 0, 32'h3F80_0000, 0, 32'h3F80_0000, 0, 0, 0, 0};
        test_directed("tie_lowest", 0);
        img = '{32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000,
                32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000};
        test_directed("signed_zero", 0);
    endtask

    task automatic test_nan();
        for (int i = 0; i < 10; i++) img[i] = 32'h3F80_0000;
        img[4] = 32'h7FC0_0001;
        test_directed("nan_mixed", 1);
        img = '{32'h7FC0_0001, 32'hFFFF_FFFF, 32'h7F80_0001, 32'hFFC0_0000, 32'h7FFF_FFFF,
                32'h7FC0_0001, 32'hFF80_0001, 32'h7FC0_0000, 32'h7FA0_0000, 32'hFFC1_2345};
        test_directed("all_nan", 0);
    endtask

    task automatic test_stray_done();
        rv_before = rv_count;
        pe_out    = 32'h7F80_0000;
        done_flag = 1'b1;
        repeat (3) tick();
        pe_out = 32'h7FC0_0001;
        tick();
        done_flag = 1'b0;
        n_checks++; if (class_idx !== exp_idx) begin n_fail++; $display("FAIL stray class_idx: got %0d exp %0d", class_idx, exp_idx); end
        n_checks++; if (max_val !== exp_val) begin n_fail++; $display("FAIL stray max_val: got %h exp %h", max_val, exp_val); end
        n_checks++; if (nan_seen !== exp_nan) begin n_fail++; $display("FAIL stray nan_seen: got %b exp %b", nan_seen, exp_nan); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL stray state: got %0d exp 0", fsm_state); end
        n_checks++; if (rv_count !== rv_before) begin n_fail++; $display("FAIL stray pulse count: got %0d exp 0", rv_count - rv_before); end
    endtask

    task automatic test_abort();
        rv_before = rv_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pe_out    = 32'h40A0_0000;
            done_flag = 1'b1;
            tick();
        end
        start  = 1'b1;
        pe_out = 32'h7F80_0000;
        tick();
        start     = 1'b0;
        done_flag = 1'b0;
        for (int i = 0; i < 9; i++) img[i] = 32'h3F80_0000;
        img[9] = 32'h4000_0000;
        model_image();
        run_image(0, 1'b0);
        n_checks++; if (class_idx !== exp_idx) begin n_fail++; $display("FAIL abort class_idx: got %0d exp %0d", class_idx, exp_idx); end
        n_checks++; if (max_val !== exp_val) begin n_fail++; $display("FAIL abort max_val: got %h exp %h", max_val, exp_val); end
        tick();
        n_checks++; if (rv_count - rv_before !== 1) begin n_fail++; $display("FAIL abort pulse count: got %0d exp 1", rv_count - rv_before); end
    endtask

    task automatic test_async_reset();
        rv_before = rv_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pe_out    = (i == 2) ? 32'h7FC0_0001 : 32'h4040_0000;
            done_flag = 1'b1;
            tick();
        end
        done_flag = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL async class_idx: got %0d exp 0", class_idx); end
        n_checks++; if (max_val !== 32'h0) begin n_fail++; $display("FAIL async max_val: got %h exp 00000000", max_val); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async busy: got %b exp 0", busy); end
        n_checks++; if (nan_seen !== 1'b0) begin n_fail++; $display("FAIL async nan_seen: got %b exp 0", nan_seen); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL async state: got %0d exp 0", fsm_state); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        n_checks++; if (rv_count !== rv_before) begin n_fail++; $display("FAIL async pulse count: got %0d exp 0", rv_count - rv_before); end
        img = '{32'hBF80_0000, 32'h3E80_0000, 32'h3F00_0000, 32'h4120_0000, 32'h0000_0001,
                32'h4110_0000, 32'h8000_0000, 32'h3F80_0000, 32'h4120_0000, 32'hC120_0000};
        test_directed("after_reset", 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 10; i++) img[i] = rand_score();
            model_image();
            exp_q.push_back({exp_nan, exp_idx, exp_val});
            rv_before = rv_count;
            run_image(2, 1'b1);
            exp_item = exp_q.pop_front();
            n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL random[%0d] result_valid: got %b exp 1", n, result_valid); end
            n_checks++; if (class_idx !== exp_item[35:32]) begin n_fail++; $display("FAIL random[%0d] class_idx: got %0d exp %0d", n, class_idx, exp_item[35:32]); end
            n_checks++; if (max_val !== exp_item[31:0]) begin n_fail++; $display("FAIL random[%0d] max_val: got %h exp %h", n, max_val, exp_item[31:0]); end
            n_checks++; if (nan_seen !== exp_item[36]) begin n_fail++; $display("FAIL random[%0d] nan_seen: got %b exp %b", n, nan_seen, exp_item[36]); end
            repeat ($urandom_range(1, 3)) tick();
            n_checks++; if (rv_count - rv_before !== 1) begin n_fail++; $display("FAIL random[%0d] pulse count: got %0d exp 1", n, rv_count - rv_before); end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_nan();
        test_stray_done();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
